// File: rtl/host_mem_responder.sv
// ---------------------------------------------------------------------------
// host_mem_responder
//   Host-side memory model that answers the accelerator wrapper's word
//   read/write protocol. Single and burst accesses are served from an
//   internal 32-bit word array after a programmable response latency.
//   It is also used to preload and dump test data.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   read_enable/addr/size      read request (or burst continuation in GAP)
//   finish_read                initiator pulse in RD_GAP: next beat follows
//   read_ready[63:0]           1 for exactly one cycle per read beat
//   read_data[31:0]            word data, valid while read_ready=1
//   write_enable/addr/size     write request (or burst continuation in GAP)
//   write_data[31:0]           word to write
//   finish_write               initiator pulse in WR_GAP: next beat follows
//   write_ready[63:0]          1 for exactly one cycle per committed beat
//   err                        sticky: out-of-range address or size != 4
//
// Optional feature (macro MEM_RESP_STATS_EN):
//   rd_beats[31:0], wr_beats[31:0], oor_cnt[15:0] saturating beat counters.
// ---------------------------------------------------------------------------
module host_mem_responder #(
    parameter int          DEPTH    = 8192,
    parameter int          ADDR_WID = 13,
    parameter logic [63:0] BASE     = 64'h0,
    parameter int          LAT      = 3,
    parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [63:0] read_addr,
    input  logic [63:0] read_size,
    input  logic        finish_read,
    output logic [63:0] read_ready,
    output logic [31:0] read_data,
    input  logic        write_enable,
    input  logic [63:0] write_addr,
    input  logic [63:0] write_size,
    input  logic [31:0] write_data,
    input  logic        finish_write,
    output logic [63:0] write_ready,
    output logic        err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0] rd_beats,
    output logic [31:0] wr_beats,
    output logic [15:0] oor_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_RESP, RD_GAP, WR_WAIT, WR_RESP, WR_GAP
    } state_t;

    // Last value of the wait counter before moving to RESP.
    localparam logic [7:0] LAT_LAST = (LAT == 0) ? 8'd0 : 8'(LAT - 1);

    state_t      state_reg, state_next;
    logic [63:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic [31:0] rdata_reg;
    logic        accept_rd, accept_wr;
    logic        addr_ok;

    logic [31:0] mem [DEPTH];

    // Offset form avoids overflow of BASE + 4*DEPTH near the top of the map.
    function automatic logic in_range(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        in_range = (a >= BASE) && (off < (64'(DEPTH) << 2)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [ADDR_WID-1:0] idx_of(input logic [63:0] a);
        idx_of = ADDR_WID'((a - BASE) >> 2);
    endfunction

    assign addr_ok = in_range(addr_reg);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Read wins a tie; a held write_enable is picked up on return.
                if (read_enable)       accept_rd = 1'b1;
                else if (write_enable) accept_wr = 1'b1;
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_reg == LAT_LAST) begin
                    state_next = (state_reg == RD_WAIT) ? RD_RESP : WR_RESP;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RD_RESP: begin
                state_next = RD_GAP;
                if (!addr_ok) err_next = 1'b1;
            end
            WR_RESP: begin
                state_next = WR_GAP;
                if (!addr_ok) err_next = 1'b1;
            end
            RD_GAP: begin
                // Burst continuation and fresh request take the same path.
                if (read_enable && finish_read) accept_rd = 1'b1;
                else if (read_enable)           accept_rd = 1'b1;
                else                            state_next = IDLE;
            end
            WR_GAP: begin
                if (write_enable && finish_write) accept_wr = 1'b1;
                else if (write_enable)            accept_wr = 1'b1;
                else                              state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (accept_rd) begin
            addr_next  = read_addr;
            cnt_next   = 8'd0;
            state_next = (LAT == 0) ? RD_RESP : RD_WAIT;
            if (read_size != 64'd4) err_next = 1'b1;
        end
        if (accept_wr) begin
            addr_next  = write_addr;
            wdata_next = write_data;
            cnt_next   = 8'd0;
            state_next = (LAT == 0) ? WR_RESP : WR_WAIT;
            if (write_size != 64'd4) err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= 64'd0;
            wdata_reg <= 32'd0;
            cnt_reg   <= 8'd0;
            err_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            // Fetch on entry to RD_RESP; with LAT=0 that is the accept edge,
            // so the address comes from the next-state path.
            if (state_next == RD_RESP)
                rdata_reg <= in_range(addr_next) ? mem[idx_of(addr_next)] : BAD_DATA;
        end
    end

    // Array is never reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (state_reg == WR_RESP && addr_ok)
            mem[idx_of(addr_reg)] <= wdata_reg;
    end

    // Ready is a state decode so that reset removes it immediately.
    assign read_ready  = {63'd0, state_reg == RD_RESP};
    assign write_ready = {63'd0, state_reg == WR_RESP};
    assign read_data   = rdata_reg;
    assign err         = err_reg;

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_beats <= 32'd0;
            wr_beats <= 32'd0;
            oor_cnt  <= 16'd0;
        end else begin
            if (state_reg == RD_RESP && rd_beats != 32'hFFFF_FFFF)
                rd_beats <= rd_beats + 32'd1;
            if (state_reg == WR_RESP && wr_beats != 32'hFFFF_FFFF)
                wr_beats <= wr_beats + 32'd1;
            if ((state_reg == RD_RESP || state_reg == WR_RESP) && !addr_ok
                && oor_cnt != 16'hFFFF)
                oor_cnt <= oor_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_host_mem_responder.sv
module tb_host_mem_responder;

    localparam int          LAT      = 3;
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable, finish_read;
    logic [63:0] read_addr, read_size;
    logic [63:0] read_ready;
    logic [31:0] read_data;
    logic        write_enable, finish_write;
    logic [63:0] write_addr, write_size;
    logic [31:0] write_data;
    logic [63:0] write_ready;
    logic        err;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_beats, wr_beats;
    logic [15:0] oor_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_q [$];
    logic [31:0] model [logic [63:0]];

    always #5 clk = ~clk;

    host_mem_responder #(
        .DEPTH(8192), .ADDR_WID(13), .BASE(64'h0), .LAT(LAT), .BAD_DATA(BAD_DATA)
    ) dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
        .finish_read(finish_read), .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_size(write_size),
        .write_data(write_data), .finish_write(finish_write), .write_ready(write_ready),
        .err(err)
`ifdef MEM_RESP_STATS_EN
        , .rd_beats(rd_beats), .wr_beats(wr_beats), .oor_cnt(oor_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_word(input logic [63:0] a);
        if (a >= 64'h8000 || a[1:0] != 2'b00) return BAD_DATA;
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    // Called at a negedge after a read was driven; returns at the GAP negedge.
    task automatic wait_rd(input string tag);
        int n;
        logic [31:0] exp;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!read_ready[0] && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'(LAT + 1));
        chk({tag, "_ready"}, read_ready, 64'd1);
        if (rd_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = rd_q.pop_front();
            chk({tag, "_data"}, 64'(read_data), 64'(exp));
        end
        $display("read  addr=%h data=%h latency=%0d", dut.addr_reg, read_data, n);
        @(negedge clk);
        chk({tag, "_gap"}, read_ready, 64'd0);
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!write_ready[0] && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'(LAT + 1));
        chk({tag, "_ready"}, write_ready, 64'd1);
        $display("write addr=%h latency=%0d", write_addr, n);
        @(negedge clk);
        chk({tag, "_gap"}, write_ready, 64'd0);
    endtask

    task automatic read_beat(input string tag, input logic [63:0] a,
                             input logic [63:0] sz, input bit cont);
        read_enable = 1'b1;
        read_addr   = a;
        read_size   = sz;
        finish_read = cont;
        rd_q.push_back(expect_word(a));
        wait_rd(tag);
        finish_read = 1'b0;
    endtask

    task automatic write_beat(input string tag, input logic [63:0] a,
                              input logic [31:0] d, input bit cont);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        write_size   = 64'd4;
        finish_write = cont;
        wait_wr(tag);
        finish_write = 1'b0;
        if (a < 64'h8000 && a[1:0] == 2'b00) model[a] = d;
    endtask

    task automatic rd_end();
        read_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_end();
        write_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        read_enable = 0; finish_read = 0; read_addr = 0; read_size = 4;
        write_enable = 0; finish_write = 0; write_addr = 0; write_size = 4; write_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_read_ready", read_ready, 64'd0);
        chk("rst_read_data", 64'(read_data), 64'd0);
        chk("rst_write_ready", write_ready, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: preload mem[5] then single read of 0x14.
        write_beat("t1_pre", 64'h14, 32'h1234, 1'b0);
        wr_end();
        read_beat("t1_rd", 64'h14, 64'd4, 1'b0);
        rd_end();

        // Test 2: burst write then burst read of words 0..3.
        for (int i = 0; i < 4; i++)
            write_beat("t2_wr", 64'(4 * i), 32'h5500_0000 + 32'(i * 17), i != 0);
        wr_end();
        for (int i = 0; i < 4; i++)
            read_beat("t2_rd", 64'(4 * i), 64'd4, i != 0);
        rd_end();
        chk("t2_err", 64'(err), 64'd0);

        // Test 3: burst write A0..A3 to 0x100, read back.
        for (int i = 0; i < 4; i++)
            write_beat("t3_wr", 64'h100 + 64'(4 * i), 32'hA0 + 32'(i), i != 0);
        wr_end();
        for (int i = 0; i < 4; i++)
            read_beat("t3_rd", 64'h100 + 64'(4 * i), 64'd4, i != 0);
        rd_end();
        chk("t3_err", 64'(err), 64'd0);

        // Test 4: out-of-range read, then out-of-range write aliasing word 0.
        read_beat("t4_rd_oor", 64'h8000, 64'd4, 1'b0);
        rd_end();
        chk("t4_err_set", 64'(err), 64'd1);
        write_beat("t4_wr_oor", 64'h8000, 32'h0BAD0BAD, 1'b0);
        wr_end();
        read_beat("t4_word0_kept", 64'h0, 64'd4, 1'b0);
        rd_end();
        chk("t4_err_sticky", 64'(err), 64'd1);

        // Test 5: simultaneous read and write to the same word.
        write_beat("t5_pre", 64'h200, 32'h0000_7777, 1'b0);
        wr_end();
        read_enable = 1'b1; read_addr = 64'h200; read_size = 4;
        write_enable = 1'b1; write_addr = 64'h200; write_data = 32'h0000_8888;
        write_size = 4;
        rd_q.push_back(32'h0000_7777);
        wait_rd("t5_rd_first");
        read_enable = 1'b0;
        @(negedge clk);
        chk("t5_no_early_wr", write_ready, 64'd0);
        wait_wr("t5_wr_after");
        wr_end();
        model[64'h200] = 32'h0000_8888;
        read_beat("t5_rd_new", 64'h200, 64'd4, 1'b0);
        rd_end();

        // Test 6: reset during RD_WAIT of a burst.
        read_enable = 1'b1; read_addr = 64'h100; read_size = 4;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_ready_in_rst", read_ready, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        read_enable = 1'b0;
        chk("t6_err_cleared", 64'(err), 64'd0);
        chk("t6_data_cleared", 64'(read_data), 64'd0);
`ifdef MEM_RESP_STATS_EN
        chk("t6_rd_beats", 64'(rd_beats), 64'd0);
        chk("t6_wr_beats", 64'(wr_beats), 64'd0);
        chk("t6_oor_cnt", 64'(oor_cnt), 64'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_ready", read_ready, 64'd0);
        end
        read_beat("t6_after_rst", 64'h104, 64'd4, 1'b0);
        rd_end();
        chk("t6_err_clean", 64'(err), 64'd0);

        // Illegal size: beat is still served, err is raised.
        read_beat("sz_rd", 64'h108, 64'd8, 1'b0);
        rd_end();
        chk("sz_err", 64'(err), 64'd1);
        chk("sb_drained", 64'(rd_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
